data_load_requester: RTL and testbench

Initiator side of the byte-wide data memory interface: accepts byte/half/word load requests from the execute stage, issues sequential byte addresses to the data memory, waits on `mem_hit`, and assembles the returned bytes little-endian into a 32-bit, sign- or zero-extended result. It sits between the pipeline's memory stage and the data memory, and owns all multi-cycle sequencing so the memory can stay a single-byte, single-cycle responder.

---
 rtl/mem_pkg.sv | 36 +++
 rtl/load_extend.sv | 29 ++
 rtl/data_load_requester.sv | 136 +++++++++++++
 tb/tb_data_load_requester.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared types for the data-memory load path.
//   load_size_e  : BYTE/HALF/WORD encodings matching req_size
//   lsm_state_e  : requester FSM states
//   size_bytes() : load size -> number of bytes N (1/2/4)
//   to_size()    : raw req_size -> load_size_e (reserved 2'b11 becomes WORD)
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } load_size_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FETCH = 2'b01,
    S_DONE  = 2'b10
  } lsm_state_e;

  function automatic logic [2:0] size_bytes(input load_size_e sz);
    case (sz)
      SZ_BYTE: size_bytes = 3'd1;
      SZ_HALF: size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

  function automatic load_size_e to_size(input logic [1:0] raw);
    case (raw)
      2'b00:   to_size = SZ_BYTE;
      2'b01:   to_size = SZ_HALF;
      default: to_size = SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// load_extend: combinational size/sign extension of the assembled load bytes.
//   asm_data : little-endian assembled bytes (only the low N bytes are meaningful)
//   size     : load size (BYTE/HALF/WORD)
//   sgn      : 1 = sign-extend from bit 8*N-1, 0 = zero-extend
//   ext_data : 32-bit extended result
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] asm_data,
  input  load_size_e  size,
  input  logic        sgn,
  output logic [31:0] ext_data
);

  logic fill_b, fill_h;

  assign fill_b = sgn & asm_data[7];
  assign fill_h = sgn & asm_data[15];

  always_comb begin
    ext_data = asm_data;
    case (size)
      SZ_BYTE: ext_data = {{24{fill_b}}, asm_data[7:0]};
      SZ_HALF: ext_data = {{16{fill_h}}, asm_data[15:0]};
      default: ext_data = asm_data;
    endcase
  end

endmodule

// File: rtl/data_load_requester.sv
// data_load_requester: initiator side of the byte-wide data memory.
// Accepts byte/half/word loads, walks sequential byte addresses toward the
// memory, stalls on mem_hit=0, and returns a little-endian, sign/zero
// extended 32-bit result as a one-cycle resp_valid pulse.
//
// Ports:
//   clk, reset                  : clock, async active-high reset
//   req_valid/req_ready         : load request handshake (ready only in IDLE)
//   req_addr/req_size/req_signed: first byte address, 00/01/10(11) size, sign
//   mem_req/mem_addr            : byte address toward memory (registered)
//   mem_hit/mem_data            : returned byte, valid when mem_hit=1
//   resp_valid/resp_data/resp_err: result pulse, data, misalignment error
//
// Build option: LOAD_MISALIGN_CHECK_EN -- when defined, misaligned half/word
// loads skip the memory and respond with resp_err=1, resp_data=0. Otherwise
// resp_err is tied low and misaligned loads run byte by byte.
module data_load_requester
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_hit,
  input  logic [7:0]        mem_data,
  output logic              resp_valid,
  output logic [31:0]       resp_data,
  output logic              resp_err
);

  lsm_state_e       state;
  load_size_e       size_q;
  logic             sgn_q;
  logic [1:0]       cnt;
  logic [3:0][7:0]  asm_q;
  logic [3:0][7:0]  asm_nxt;
  logic [1:0]       last_idx;
  logic [31:0]      ext_data;
  load_size_e       req_sz;

  assign req_ready = (state == S_IDLE);
  assign mem_req   = (state == S_FETCH);
  assign req_sz    = to_size(req_size);
  assign last_idx  = 2'(size_bytes(size_q) - 3'd1);

  // Assembly register with the current byte merged in, so the final byte
  // lands in resp_data on the same edge that moves the FSM to DONE.
  always_comb begin
    asm_nxt      = asm_q;
    asm_nxt[cnt] = mem_data;
  end

  load_extend u_ext (
    .asm_data (asm_nxt),
    .size     (size_q),
    .sgn      (sgn_q),
    .ext_data (ext_data)
  );

`ifdef LOAD_MISALIGN_CHECK_EN
  logic err_q;
  logic misaligned;

  assign misaligned = ((req_sz == SZ_HALF) && req_addr[0]) ||
                      ((req_sz == SZ_WORD) && (req_addr[1:0] != 2'b00));
  assign resp_err   = err_q;
`else
  assign resp_err   = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      size_q     <= SZ_BYTE;
      sgn_q      <= 1'b0;
      cnt        <= 2'd0;
      asm_q      <= '0;
      mem_addr   <= '0;
      resp_valid <= 1'b0;
      resp_data  <= 32'd0;
`ifdef LOAD_MISALIGN_CHECK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      resp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            size_q   <= req_sz;
            sgn_q    <= req_signed;
            mem_addr <= req_addr;
            cnt      <= 2'd0;
            asm_q    <= '0;
`ifdef LOAD_MISALIGN_CHECK_EN
            if (misaligned) begin
              state      <= S_DONE;
              resp_valid <= 1'b1;
              resp_data  <= 32'd0;
              err_q      <= 1'b1;
            end else begin
              state <= S_FETCH;
            end
`else
            state <= S_FETCH;
`endif
          end
        end
        S_FETCH: begin
          if (mem_hit) begin
            asm_q    <= asm_nxt;
            cnt      <= cnt + 2'd1;
            mem_addr <= mem_addr + ADDR_W'(1);
            if (cnt == last_idx) begin
              state      <= S_DONE;
              resp_valid <= 1'b1;
              resp_data  <= ext_data;
`ifdef LOAD_MISALIGN_CHECK_EN
              err_q      <= 1'b0;
`endif
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_load_requester.sv
// tb_data_load_requester: scoreboard bench for data_load_requester.
// Memory model returns mem_addr[7:0] with mem_hit=1 unless the stimulus
// stalls it; expected responses are queued at acceptance and checked when
// resp_valid pulses.
module tb_data_load_requester;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_signed;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_hit;
  logic [7:0]  mem_data;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;

  logic        hit_en;
  logic        mem_req_seen;
  int          cyc;
  int          acc_cyc;
  int          n_chk;
  int          n_err;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];

  data_load_requester #(.ADDR_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_size   (req_size),
    .req_signed (req_signed),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_hit    (mem_hit),
    .mem_data   (mem_data),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  // Garbage byte while not hitting, so a capture during a stall shows up.
  assign mem_hit  = mem_req & hit_en;
  assign mem_data = mem_hit ? mem_addr[7:0] : 8'hEE;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_req) mem_req_seen <= 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && resp_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_data", resp_data, e.data);
        chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
        chk("latency", 32'(cyc - acc_cyc + 1), 32'(e.lat));
      end
    end
  end

  task automatic wait_ready();
    int budget = 50;
    while (!req_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!req_ready) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_accept(input logic [31:0] addr, input logic [1:0] sz, input logic sgn);
    wait_ready();
    req_valid  = 1'b1;
    req_addr   = addr;
    req_size   = sz;
    req_signed = sgn;
    @(posedge clk);
    #1;
    acc_cyc   = cyc;
    req_valid = 1'b0;
    req_addr  = 32'hDEAD_BEEF;
  endtask

  // Issue one load; stalls = mem_hit-low cycles inserted after the first byte.
  task automatic load(input logic [31:0] addr, input logic [1:0] sz, input logic sgn,
                      input logic [31:0] exp_data, input logic exp_err,
                      input int exp_lat, input int stalls);
    int budget;
    exp_t e;
    do_accept(addr, sz, sgn);
    e.data = exp_data;
    e.err  = exp_err;
    e.lat  = exp_lat;
    sb.push_back(e);
    if (!exp_err) begin
      @(negedge clk);
      chk("addr_first", mem_addr, addr);
      @(posedge clk);
      if (stalls > 0) begin
        #1 hit_en = 1'b0;
        repeat (stalls) begin
          @(negedge clk);
          chk("stall_addr", mem_addr, addr + 32'd1);
          @(posedge clk);
        end
        #1 hit_en = 1'b1;
      end else begin
        @(negedge clk);
        chk("addr_second", mem_addr, addr + 32'd1);
      end
    end
    budget = 40;
    while (sb.size() != 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (sb.size() != 0) begin
      chk("resp_timeout", 32'd0, 32'd1);
      sb.delete();
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    chk({tag, "_mem_req"}, {31'd0, mem_req}, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
    chk({tag, "_resp_data"}, resp_data, 32'd0);
    chk({tag, "_resp_err"}, {31'd0, resp_err}, 32'd0);
  endtask

  initial begin
    n_chk = 0; n_err = 0; cyc = 0; acc_cyc = 0;
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_size = '0; req_signed = 1'b0;
    hit_en = 1'b1; mem_req_seen = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("rst");
    reset = 1'b0;
    @(negedge clk);

    // Word, zero-extend, aligned.
    load(32'h10, 2'b10, 1'b0, 32'h1312_1110, 1'b0, 5, 0);
    repeat (3) @(negedge clk);
    chk("resp_data_hold", resp_data, 32'h1312_1110);

    // Byte signed / unsigned.
    load(32'h80, 2'b00, 1'b1, 32'hFFFF_FF80, 1'b0, 2, 0);
    load(32'h80, 2'b00, 1'b0, 32'h0000_0080, 1'b0, 2, 0);

    // Half with two stall cycles after the first byte.
    load(32'h20, 2'b01, 1'b0, 32'h0000_2120, 1'b0, 5, 2);

    // Signed half, and reserved size treated as word.
    load(32'h8E, 2'b01, 1'b1, 32'hFFFF_8F8E, 1'b0, 3, 0);
    load(32'h30, 2'b11, 1'b1, 32'h3332_3130, 1'b0, 5, 0);

    // Address wrap: 0xFFFFFFFF then 0x00000000.
    load(32'hFFFF_FFFF, 2'b01, 1'b0, 32'h0000_00FF, 1'b0, 3, 0);

    // Reset during the third byte of a word load.
    do_accept(32'h40, 2'b10, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("pre_reset_addr", mem_addr, 32'h42);
    #1 reset = 1'b1;
    #1 chk_reset_vals("async_rst");
    @(posedge clk);
    @(negedge clk);
    chk_reset_vals("held_rst");
    reset = 1'b0;
    @(negedge clk);
    load(32'h05, 2'b00, 1'b0, 32'h0000_0005, 1'b0, 2, 0);

    // Misaligned word load.
    @(negedge clk);
    mem_req_seen = 1'b0;
`ifdef LOAD_MISALIGN_CHECK_EN
    load(32'h11, 2'b10, 1'b0, 32'h0000_0000, 1'b1, 1, 0);
    repeat (2) @(negedge clk);
    chk("misalign_no_mem_req", {31'd0, mem_req_seen}, 32'd0);
`else
    load(32'h11, 2'b10, 1'b0, 32'h1413_1211, 1'b0, 5, 0);
    repeat (2) @(negedge clk);
    chk("misalign_mem_req", {31'd0, mem_req_seen}, 32'd1);
`endif

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
